jk_bank_driver: RTL and testbench
=================================

Name: jk_bank_driver

Overview:
- Driving side for a bank of WIDTH single-bit jk_flip_flop instances.
- Accepts a target word over a valid/ready handshake and computes the J/K excitation for each bit from the bank's current Q.
- Drives the excitation for exactly one clock edge, then watches Q feedback until it equals the target.
- Reports completion, or a timeout error if Q never reaches the target.

Parameters:
WIDTH, 4, number of JK flip-flops in the driven bank
TIMEOUT, 3, number of CHECK cycles allowed for q_fb to equal the target before err is raised; legal range is 1 or more

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
tgt_valid  input  1  target word offered
tgt_ready  output  1  driver can accept a target
tgt_data  input  WIDTH  requested next state of the bank
q_fb  input  WIDTH  Q outputs of the bank, one bit per flip-flop
j  output  WIDTH  J inputs to the bank
k  output  WIDTH  K inputs to the bank
busy  output  1  a transfer is in progress (DRIVE or CHECK)
done  output  1  one-cycle completion pulse
err  output  1  sticky timeout flag

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, j=0, k=0, busy=0, done=0, err=0, tgt_ready=0, target register=0, counter=0.
  - tgt_ready is registered; it rises on the first rising edge after reset deasserts.
- Reset asserted mid-operation aborts immediately: j/k drop to 0 asynchronously and no done is produced.
- All outputs are registered.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE:
  - tgt_ready=1.
  - When tgt_valid=1 at edge N:
    - latch tgt_data;
    - compute per-bit excitation from q_fb sampled at edge N;
    - register j/k;
    - set busy=1 and tgt_ready=0;
    - set err=0 (err is cleared on every acceptance);
    - go to DRIVE.
- Excitation per bit (c = q_fb bit, t = target bit):
  - c=0, t=1 → J=1, K=0.
  - c=1, t=0 → J=0, K=1.
  - c=t → J=0, K=0 (hold).
- DRIVE:
  - j/k are valid for exactly one cycle, edge N to edge N+1, so the bank captures at edge N+1.
  - At edge N+1: j=k=0, counter=1, go to CHECK.
- CHECK:
  - j=k=0.
  - Each cycle, compare q_fb with the latched target.
  - On a match at an edge: done=1 for one cycle, busy=0, tgt_ready=1, go to IDLE.
  - On a mismatch with counter=TIMEOUT: err=1 and done=1 for one cycle, then IDLE.
  - Otherwise the counter increments.
- Nominal latency: accept at edge N, bank updates at N+1, done is high in the cycle after edge N+2.
- Target equal to current Q: full DRIVE/CHECK sequence runs with j=k=0; same latency.
- tgt_valid while busy: ignored, tgt_ready=0; the source must hold the word.
- Back-to-back: done and tgt_ready are high in the same cycle, so the next target can be accepted at the very next edge.
- err stays high until the next acceptance or reset.
- Counter width is $clog2(TIMEOUT+1).

Optional Feature:
- Macro: JK_TOGGLE_EXCITE_EN.
- Defined: bits with c≠t are driven J=1, K=1 (toggle) for the single DRIVE cycle; holding bits stay J=K=0. This exercises the bank's toggle mode.
- Undefined: set/reset excitation exactly as in Behaviour.
- In both modes, j/k are nonzero for at most one cycle per transfer.

Decomposition:
- Package jk_pkg:
  - state enum (IDLE, DRIVE, CHECK);
  - 2-bit excitation constants JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11, encoded {J,K};
  - function returning the excitation for a (c, t) pair.
- One natural sub-module: jk_excite_bit, a combinational per-bit mapper generated WIDTH times. It honours JK_TOGGLE_EXCITE_EN.

Test Plan:
- Bench setup: DUT wired to 4 real jk_flip_flop instances with q_fb=q. The bank's reset is driven active-high from ~reset; clock period 50.
- Reset, then tgt_data=4'b1010 from bank 0000 → j=1010, k=0000 for one cycle; q=1010; done pulse in the cycle after edge N+2; err=0.
- Then tgt_data=4'b0110 → j=0100, k=1000 for one cycle; q=0110; done=1.
  - With JK_TOGGLE_EXCITE_EN defined: j=k=1100 instead.
- tgt_data equal to the current Q (0110) → j=k=0 throughout; done at the nominal latency.
- Force q_fb stuck at 0000 with target 1111, TIMEOUT=3 → err=1 and done=1 after 3 CHECK cycles. err clears on the next acceptance.
- Hold tgt_valid high for 3 consecutive words → each word is accepted only while tgt_ready=1; accepts are back-to-back with done.
- Assert reset during DRIVE → j=k=0, busy=0, done=0 immediately. tgt_ready=1 one edge after release.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and excitation helpers for the JK bank driver.
package jk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StCheck
    } state_t;

    // Excitation pairs, encoded {J,K}.
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    function automatic logic [1:0] jk_excite(input logic c, input logic t,
                                             input logic toggle_mode);
        logic [1:0] res;
        if (c == t) begin
            res = JK_HOLD;
        end else if (toggle_mode) begin
            res = JK_TOGGLE;
        end else if (t) begin
            res = JK_SET;
        end else begin
            res = JK_RESET;
        end
        return res;
    endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Per-bit J/K excitation mapper from current Q (c) to target (t).
// JK_TOGGLE_EXCITE_EN selects toggle excitation for changing bits.
module jk_excite_bit
    import jk_pkg::*;
(
    input  logic c,
    input  logic t,
    output logic j,
    output logic k
);

`ifdef JK_TOGGLE_EXCITE_EN
    localparam logic ToggleMode = 1'b1;
`else
    localparam logic ToggleMode = 1'b0;
`endif

    always_comb begin
        {j, k} = jk_excite(c, t, ToggleMode);
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives one-cycle J/K excitation into a JK flip-flop bank and waits for Q to match.
// Optional JK_TOGGLE_EXCITE_EN (see jk_excite_bit) uses toggle excitation.
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned TIMEOUT = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  j_q, j_d, k_q, k_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic [WIDTH-1:0]  exc_j, exc_k;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite_bit u_excite (
            .c (q_fb[i]),
            .t (tgt_data[i]),
            .j (exc_j[i]),
            .k (exc_k[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        j_d      = '0;
        k_d      = '0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        ready_d  = ready_q;

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                // ready_q gates acceptance so nothing is taken in the first post-reset cycle
                if (tgt_valid && ready_q) begin
                    target_d = tgt_data;
                    j_d      = exc_j;
                    k_d      = exc_k;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = StDrive;
                end
            end
            StDrive: begin
                cnt_d   = CntOne;
                state_d = StCheck;
            end
            StCheck: begin
                if (q_fb == target_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == CntMax) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            target_q <= '0;
            cnt_q    <= '0;
            j_q      <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            j_q      <= j_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign tgt_ready = ready_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Scoreboard bench for jk_bank_driver driving a behavioural 4-bit JK flip-flop bank.
module tb_jk_bank_driver;

    logic       clock;
    logic       reset;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] tgt_data;
    logic [3:0] q_fb;
    logic [3:0] j;
    logic [3:0] k;
    logic       busy;
    logic       done;
    logic       err;

    logic [3:0] bank_q;
    logic       bank_rst;
    logic       stuck;

    typedef struct {
        logic [3:0] tgt;
        logic [3:0] ej;
        logic [3:0] ek;
        bit         eerr;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 1'b0;
    bit   err_m  = 1'b0;

    jk_bank_driver #(
        .WIDTH   (4),
        .TIMEOUT (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_data  (tgt_data),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clock = 1'b0;
    always #25 clock = ~clock;

    // Bank of four JK flip-flops: Q+ = J & ~Q | ~K & Q.
    assign bank_rst = ~reset;
    always @(posedge clock or posedge bank_rst) begin
        if (bank_rst) bank_q <= 4'b0000;
        else          bank_q <= (j & ~bank_q) | (~k & bank_q);
    end
    assign q_fb = stuck ? 4'b0000 : bank_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always begin : monitor
        logic [3:0] xj, xk;
        bit         pend, xbusy;
        exp_t       e;
        @(posedge clock);
        cyc++;
        #1;
        if (mon_en) begin
            pend = (sb.size() > 0);
            xj = 4'b0000;
            xk = 4'b0000;
            if (pend && cyc == sb[0].acc) begin
                err_m = 1'b0;
                xj    = sb[0].ej;
                xk    = sb[0].ek;
            end
            xbusy = pend && (cyc >= sb[0].acc);
            if (done) begin
                if (!pend) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc - e.acc, e.eerr ? 4 : 2);
                    chk("done_err", {31'd0, err}, {31'd0, e.eerr});
                    if (!e.eerr) chk("q_matches_target", {28'd0, q_fb}, {28'd0, e.tgt});
                    err_m = e.eerr;
                    xbusy = 1'b0;
                end
            end else if (pend && cyc > sb[0].acc + 5) begin
                chk("done_timeout", 0, 1);
                void'(sb.pop_front());
                xbusy = 1'b0;
            end
            chk("j", {28'd0, j}, {28'd0, xj});
            chk("k", {28'd0, k}, {28'd0, xk});
            chk("busy", {31'd0, busy}, {31'd0, xbusy});
            chk("tgt_ready", {31'd0, tgt_ready}, {31'd0, !xbusy});
            chk("err_sticky", {31'd0, err}, {31'd0, err_m});
        end
    end

    // Offer one word from a negedge; returns at the negedge after acceptance.
    task automatic offer(input logic [3:0] d, input bit stk, input bit keep);
        int   n;
        exp_t e;
        logic [3:0] c;
        tgt_data  = d;
        tgt_valid = 1'b1;
        n = 0;
        while (!tgt_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!tgt_ready) begin
            chk("ready_wait", 0, 1);
            tgt_valid = 1'b0;
            return;
        end
        stuck = stk;
        c = stk ? 4'b0000 : bank_q;
`ifdef JK_TOGGLE_EXCITE_EN
        e.ej = c ^ d;
        e.ek = c ^ d;
`else
        e.ej = ~c & d;
        e.ek = c & ~d;
`endif
        e.tgt  = d;
        e.eerr = stk && (d != 4'b0000);
        e.acc  = cyc + 1;
        sb.push_back(e);
        @(negedge clock);
        if (!keep) tgt_valid = 1'b0;
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        tgt_valid = 1'b0;
        tgt_data  = 4'b0000;
        stuck     = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_j", {28'd0, j}, 0);
        chk("rst_k", {28'd0, k}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_ready", {31'd0, tgt_ready}, 0);
        reset  = 1'b1;
        mon_en = 1'b1;
        #1 chk("ready_before_first_edge", {31'd0, tgt_ready}, 0);

        offer(4'b1010, 1'b0, 1'b0);
        offer(4'b0110, 1'b0, 1'b0);
        offer(4'b0110, 1'b0, 1'b0);
        offer(4'b1111, 1'b1, 1'b0);
        offer(4'b0011, 1'b0, 1'b0);
        offer(4'b1100, 1'b0, 1'b1);
        offer(4'b0101, 1'b0, 1'b1);
        offer(4'b1001, 1'b0, 1'b0);

        // Abort in the DRIVE cycle.
        offer(4'b0110, 1'b0, 1'b0);
        chk("busy_in_drive", {31'd0, busy}, 1);
        reset  = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("abort_j", {28'd0, j}, 0);
        chk("abort_k", {28'd0, k}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_done", {31'd0, done}, 0);
        sb.delete();
        err_m = 1'b0;
        repeat (2) @(negedge clock);
        reset  = 1'b1;
        mon_en = 1'b1;
        #1 chk("abort_ready_low", {31'd0, tgt_ready}, 0);
        @(posedge clock);
        #2 chk("abort_ready_after_edge", {31'd0, tgt_ready}, 1);
        @(negedge clock);

        for (int i = 0; i < 40; i++) begin
            offer(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 1) == 1));
            if (!tgt_valid && $urandom_range(0, 2) == 0) @(negedge clock);
        end
        tgt_valid = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() > 0) chk("drain", 0, 1);
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
